// File: rtl/ahb_sram_pkg.sv
// Shared encodings for the AHB-to-SRAM bridge: bus codes, FSM states, lane mask width.
package ahb_sram_pkg;

  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_ERR1  = 3'd3,
    ST_ERR2  = 3'd4
  } state_e;

endpackage

// File: rtl/ahb_sram_lane_dec.sv
// Byte-lane decode: turns transfer size and low address bits into an SRAM byte mask.
// Purely combinational; flags sizes above a word and misaligned halves/words as invalid.
module ahb_sram_lane_dec
  import ahb_sram_pkg::*;
(
  input  logic [2:0]        hsize_i,
  input  logic [1:0]        haddr_lo_i,
  output logic [MASK_W-1:0] mask_o,
  output logic              invalid_o
);

  always_comb begin
    mask_o    = '0;
    invalid_o = 1'b0;
    case (hsize_i)
      SIZE_BYTE: mask_o = MASK_W'(1) << haddr_lo_i;
      SIZE_HALF: begin
        mask_o    = haddr_lo_i[1] ? 4'b1100 : 4'b0011;
        invalid_o = haddr_lo_i[0];
      end
      SIZE_WORD: begin
        mask_o    = 4'b1111;
        invalid_o = |haddr_lo_i;
      end
      default:   invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_bridge.sv
// Zero-wait-state AHB-Lite slave in front of a single-port SRAM with combinational read data.
// Invalid sizes/alignments get a two-cycle ERROR response; all other transfers complete in one data phase.
module ahb_sram_bridge
  import ahb_sram_pkg::*;
#(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   HSEL,
  input  logic [ADDRWIDTH+1:0]   HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic                   HREADY,
  input  logic [DATAWIDTH-1:0]   HWDATA,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic [DATAWIDTH-1:0]   HRDATA,
  output logic [ADDRWIDTH-1:0]   SRAM_ADDR,
  output logic                   SRAM_CS,
  output logic [MASK_W-1:0]      SRAM_WE,
  output logic [DATAWIDTH-1:0]   SRAM_WDATA,
  input  logic [DATAWIDTH-1:0]   SRAM_RDATA
);

  state_e                state_q, state_d;
  logic [ADDRWIDTH-1:0]  addr_q, addr_d;
  logic [MASK_W-1:0]     we_q, we_d;
  logic [MASK_W-1:0]     lane_mask;
  logic                  lane_invalid;
  logic                  accept;

  ahb_sram_lane_dec u_lane_dec (
    .hsize_i    (HSIZE),
    .haddr_lo_i (HADDR[1:0]),
    .mask_o     (lane_mask),
    .invalid_o  (lane_invalid)
  );

  // ERR1 holds the bus (HREADYOUT=0), so it never accepts and always moves on to ERR2.
  assign accept = HSEL && HREADY && (state_q != ST_ERR1) &&
                  ((HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ));

  always_comb begin
    state_d = ST_IDLE;
    addr_d  = addr_q;
    we_d    = '0;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (accept) begin
      addr_d = HADDR[ADDRWIDTH+1:2];
      if (lane_invalid) begin
        state_d = ST_ERR1;
      end else if (HWRITE) begin
        state_d = ST_WRITE;
        we_d    = lane_mask;
      end else begin
        state_d = ST_READ;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
    end
  end

  // we_q is only non-zero while in WRITE, so the SRAM strobes need no extra state gating.
  assign SRAM_CS    = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign SRAM_WE    = we_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_WDATA = HWDATA;
  assign HRDATA     = (state_q == ST_READ) ? SRAM_RDATA : '0;
  assign HREADYOUT  = (state_q != ST_ERR1);
  assign HRESP      = (state_q == ST_ERR1) || (state_q == ST_ERR2);

endmodule

// File: doc/ahb_sram_bridge.md
AHB_SRAM_BRIDGE -- requirements
Module: ahb_sram_bridge

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 16: SRAM word-address width.
REQ-002 SHALL have parameter DATAWIDTH, default 32: data width; only 32 is supported.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RSTn  in  1  reset; asynchronous, active-low.
REQ-005 HSEL  in  1  slave select.
REQ-006 HADDR  in  ADDRWIDTH+2  byte address.
REQ-007 HTRANS  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-008 HWRITE  in  1  1 = write.
REQ-009 HSIZE  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
REQ-010 HREADY  in  1  bus-level ready.
REQ-011 HWDATA  in  DATAWIDTH  write data, valid in the data phase.
REQ-012 HREADYOUT  out  1  slave ready.
REQ-013 HRESP  out  1  0 = OKAY, 1 = ERROR.
REQ-014 HRDATA  out  DATAWIDTH  read data.
REQ-015 SRAM_ADDR  out  ADDRWIDTH  SRAM word address.
REQ-016 SRAM_CS  out  1  SRAM chip select.
REQ-017 SRAM_WE  out  4  SRAM byte write enables; 0 = read.
REQ-018 SRAM_WDATA  out  DATAWIDTH  SRAM write data.
REQ-019 SRAM_RDATA  in  DATAWIDTH  SRAM combinational read data.

Function
REQ-020 Address phase SHALL be accepted when HSEL & HTRANS[1] & HREADY are all 1; otherwise the next state SHALL be IDLE.
REQ-021 FSM states SHALL be IDLE, WRITE, READ, ERR1, ERR2; an accepted valid write goes to WRITE, a valid read to READ, an invalid transfer to ERR1.
REQ-022 A transfer SHALL be invalid when any of the following holds: HSIZE>2; HSIZE=1 with HADDR[0]=1; HSIZE=2 with HADDR[1:0]!=0.
REQ-023 Byte mask SHALL be: HSIZE=0 -> 1<<HADDR[1:0]; HSIZE=1 -> HADDR[1] ? 4'b1100 : 4'b0011; HSIZE=2 -> 4'b1111.
REQ-024 SRAM_ADDR SHALL be HADDR[ADDRWIDTH+1:2], registered at address-phase acceptance.
REQ-025 SRAM_WE SHALL be the byte mask registered on acceptance of a write, and 0 otherwise.
REQ-026 In WRITE, SRAM_CS=1 and SRAM_WDATA=HWDATA (combinational pass-through); the SRAM commits on the edge ending the data phase.
REQ-027 In READ, SRAM_CS=1, SRAM_WE=0 and HRDATA=SRAM_RDATA (combinational); in all other states HRDATA=0.
REQ-028 In IDLE, WRITE and READ: HREADYOUT=1, HRESP=0 (zero wait states).
REQ-029 In ERR1: HREADYOUT=0, HRESP=1. In ERR2: HREADYOUT=1, HRESP=1. ERR1 SHALL always advance to ERR2.
REQ-030 ERR1 and ERR2 SHALL perform no SRAM access (SRAM_CS=0, SRAM_WE=0).
REQ-031 A new address phase SHALL be accepted in any state where HREADY=1, including ERR2 (pipelined back-to-back transfers).
REQ-032 Read immediately after write to the same address SHALL return the new data with no stall, because the write commits before the read data phase.
REQ-033 IDLE or BUSY transfers SHALL give an OKAY response with no SRAM access.
REQ-034 SRAM_CS SHALL be 0 whenever the bridge is not in the WRITE or READ state.

Reset
REQ-035 On RSTn=0, asynchronously: state=IDLE, SRAM_CS=0, SRAM_WE=0, SRAM_ADDR=0, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-036 A reset asserted mid-transfer (WRITE, READ, ERR1 or ERR2) SHALL abort the transfer; no partial SRAM write occurs after reset is asserted.

Structure
REQ-037 Package ahb_sram_pkg SHALL hold the HTRANS and HSIZE encodings, the FSM state enum and the byte-mask width constant.
REQ-038 Lane and alignment decode SHALL be sub-module ahb_sram_lane_dec: inputs HSIZE and HADDR[1:0]; outputs the byte mask and an invalid flag.

Verification
REQ-039 Word write 0xDEADBEEF to 0x0010, then read 0x0010 -> SRAM_ADDR=4, SRAM_WE=4'hF; HRDATA=0xDEADBEEF, zero wait states.
REQ-040 Byte write 0xAA to 0x0013, then read word 0x0010 -> SRAM_WE=4'b1000; read returns 0xAAADBEEF.
REQ-041 Half write 0x1234 to 0x0012 immediately followed by a read of 0x0010 -> read returns 0x1234BEEF with no stall.
REQ-042 Word read at 0x0011 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); SRAM_CS stays 0.
REQ-043 RSTn pulsed low during the WRITE data phase -> all outputs return to reset values; the subsequent read at that address returns 0.
